// File: rtl/exe_stage_if.sv
// Pipeline handshake between decode, execute and memory stages.
// valid/allowin: a stage transfers an instruction on a clock edge where its valid and the next stage's allowin are both high.
interface exe_stage_if;
    logic         ds_to_es_valid;
    logic [215:0] ds_to_es_bus;
    logic         es_allowin;
    logic         es_to_ms_valid;
    logic [133:0] es_to_ms_bus;
    logic         ms_allowin;

    // master: the surrounding pipeline (decode feeds in, mem accepts)
    modport master (
        output ds_to_es_valid, ds_to_es_bus, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus
    );

    // slave: the execute stage itself
    modport slave (
        input  ds_to_es_valid, ds_to_es_bus, ms_allowin,
        output es_allowin, es_to_ms_valid, es_to_ms_bus
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: one-instruction pipeline slot, ALU, data-SRAM request with
// alignment check, and a 32-step restoring signed/unsigned divider.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic [31:0] sra_res;
    assign sra_res = $signed(alu_src1) >>> alu_src2[4:0];

    // alu_op is one-hot: add sub slt sltu and nor or xor sll srl sra lui
    assign alu_result = ({32{alu_op[0]}}  & (alu_src1 + alu_src2))
                      | ({32{alu_op[1]}}  & (alu_src1 - alu_src2))
                      | ({32{alu_op[2]}}  & {31'b0, $signed(alu_src1) < $signed(alu_src2)})
                      | ({32{alu_op[3]}}  & {31'b0, alu_src1 < alu_src2})
                      | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[10]}} & sra_res)
                      | ({32{alu_op[11]}} & alu_src2);
endmodule

module exe_stage (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  pipe,
    output logic [38:0] es_to_ds_forward_bus,
    output logic        es_to_ds_valid,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic [31:0] div_result,
    output logic [31:0] mod_result,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    output logic [1:0]  div_state_dbg
);
    typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_t;

    logic         es_valid, es_ready_go, flush;
    logic [215:0] es_bus;
    div_state_t   div_state, div_state_nxt;
    logic         div_start, div_step;

    // DS->ES layout from MSB: 4 reserved bits, then the ES->MS fields (minus result),
    // store_op, div_signed and the ALU operands, with pc in the low word.
    logic        mem_sign_ext, csr_we, inst_ertn, excp_in, load_op, store_op, div_signed, gr_we;
    logic [6:0]  excp_num_in;
    logic [13:0] csr_idx;
    logic [31:0] csr_result, alu_src1, alu_src2, rkd_value, pc, alu_result;
    logic [1:0]  mem_size;
    logic [3:0]  mul_div_op;
    logic [4:0]  dest;
    logic [11:0] alu_op;

    assign mem_sign_ext = es_bus[211];
    assign excp_num_in  = es_bus[210:204];
    assign csr_we       = es_bus[203];
    assign csr_idx      = es_bus[202:189];
    assign csr_result   = es_bus[188:157];
    assign inst_ertn    = es_bus[156];
    assign excp_in      = es_bus[155];
    assign mem_size     = es_bus[154:153];
    assign mul_div_op   = es_bus[152:149];
    assign load_op      = es_bus[148];
    assign store_op     = es_bus[147];
    assign div_signed   = es_bus[146];
    assign gr_we        = es_bus[145];
    assign dest         = es_bus[144:140];
    assign alu_op       = es_bus[139:128];
    assign alu_src1     = es_bus[127:96];
    assign alu_src2     = es_bus[95:64];
    assign rkd_value    = es_bus[63:32];
    assign pc           = es_bus[31:0];

    assign flush = excp_flush | ertn_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                es_valid <= 1'b0;
        else if (flush)           es_valid <= 1'b0;
        else if (pipe.es_allowin) es_valid <= pipe.ds_to_es_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          es_bus <= '0;
        else if (pipe.ds_to_es_valid && pipe.es_allowin)    es_bus <= pipe.ds_to_es_bus;
    end

    alu u_alu (.alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result));

    // Alignment exception only raised when no earlier exception is already carried.
    logic is_mem, misaligned, ale, excp_out;
    logic [6:0] excp_num_out;
    assign is_mem       = load_op | store_op;
    assign misaligned   = (mem_size == 2'b01 && alu_result[0]) || (mem_size[1] && alu_result[1:0] != 2'b00);
    assign ale          = is_mem & ~excp_in & misaligned;
    assign excp_out     = excp_in | ale;
    assign excp_num_out = {excp_num_in[6] | ale, excp_num_in[5:0]};

    assign pipe.es_allowin     = ~es_valid | (es_ready_go & pipe.ms_allowin);
    assign pipe.es_to_ms_valid = es_valid & es_ready_go;
    assign pipe.es_to_ms_bus   = {mem_sign_ext, excp_num_out, csr_we, csr_idx, csr_result, inst_ertn,
                                  excp_out, mem_size, mul_div_op, load_op, gr_we, dest, alu_result, pc};

    assign es_to_ds_valid       = es_valid;
    assign es_to_ds_forward_bus = {load_op, es_valid & gr_we & (dest != 5'd0), dest, alu_result};

    // Request only on the transfer cycle so each memory op issues exactly once.
    assign data_sram_en   = es_valid & is_mem & ~excp_out & ~flush & es_ready_go & pipe.ms_allowin;
    assign data_sram_addr = alu_result;

    always_comb begin
        data_sram_we    = 4'b0000;
        data_sram_wdata = rkd_value;
        case (mem_size)
            2'b00: begin
                if (store_op) data_sram_we = 4'b0001 << alu_result[1:0];
                data_sram_wdata = {4{rkd_value[7:0]}};
            end
            2'b01: begin
                if (store_op) data_sram_we = alu_result[1] ? 4'b1100 : 4'b0011;
                data_sram_wdata = {2{rkd_value[15:0]}};
            end
            default: if (store_op) data_sram_we = 4'b1111;
        endcase
    end

    assign mul_src1 = alu_src1;
    assign mul_src2 = alu_src2;

    // Divider: magnitudes in, sign fixed up on the last step.
    logic        is_div, div_qneg, div_rneg, div_zero, src1_neg, src2_neg, div_ge;
    logic [4:0]  div_cnt;
    logic [31:0] div_r, div_q, div_d, div_r_nxt, div_q_nxt, q_fin, r_fin;
    logic [32:0] div_tmp, div_diff;

    assign is_div    = mul_div_op[2] | mul_div_op[3];
    assign src1_neg  = div_signed & alu_src1[31];
    assign src2_neg  = div_signed & alu_src2[31];
    assign div_tmp   = {div_r, div_q[31]};
    assign div_diff  = div_tmp - {1'b0, div_d};
    assign div_ge    = ~div_diff[32];
    assign div_r_nxt = div_ge ? div_diff[31:0] : div_tmp[31:0];
    assign div_q_nxt = {div_q[30:0], div_ge};
    assign q_fin     = div_zero ? 32'hFFFF_FFFF : (div_qneg ? -div_q_nxt : div_q_nxt);
    assign r_fin     = div_rneg ? -div_r_nxt : div_r_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_state <= DIV_IDLE;
        else       div_state <= div_state_nxt;
    end

    always_comb begin
        div_state_nxt = div_state;
        case (div_state)
            DIV_IDLE: if (es_valid && is_div && !flush) div_state_nxt = DIV_BUSY;
            DIV_BUSY: if (flush) div_state_nxt = DIV_IDLE;
                      else if (div_cnt == 5'd31) div_state_nxt = DIV_DONE;
            DIV_DONE: if (flush || pipe.ms_allowin) div_state_nxt = DIV_IDLE;
            default:  div_state_nxt = DIV_IDLE;
        endcase
    end

    always_comb begin
        es_ready_go = ~is_div | (div_state == DIV_DONE);
        div_start   = (div_state == DIV_IDLE) & es_valid & is_div & ~flush;
        div_step    = (div_state == DIV_BUSY) & ~flush;
    end

    assign div_state_dbg = div_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0; div_r <= '0; div_q <= '0; div_d <= '0;
            div_qneg <= 1'b0; div_rneg <= 1'b0; div_zero <= 1'b0;
            div_result <= '0; mod_result <= '0;
        end else if (div_start) begin
            div_cnt  <= '0;
            div_r    <= '0;
            div_q    <= src1_neg ? -alu_src1 : alu_src1;
            div_d    <= src2_neg ? -alu_src2 : alu_src2;
            div_qneg <= src1_neg ^ src2_neg;
            div_rneg <= src1_neg;
            div_zero <= (alu_src2 == 32'd0);
        end else if (div_step) begin
            div_r   <= div_r_nxt;
            div_q   <= div_q_nxt;
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'd31) begin
                div_result <= q_fin;
                mod_result <= r_fin;
            end
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: drives instructions through the stage interface and
// checks transfers to MEM against an expected queue.
module tb_exe_stage;
    localparam int W = 139;

    logic        clk = 1'b0;
    logic        reset;
    logic [38:0] fwd_bus;
    logic        es_to_ds_valid, data_sram_en, excp_flush, ertn_flush;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata, mul_src1, mul_src2, div_result, mod_result;
    logic [1:0]  div_state;

    int n_chk = 0, n_bad = 0, cyc = 0, en_cnt = 0, mon_t;
    logic [3:0]   last_we;
    logic [31:0]  last_wdata, last_addr;
    logic [W-1:0] exp_q[$];
    int           t_q[$];
    logic [W-1:0] mon_e;

    always #5 clk = ~clk;

    exe_stage_if pipe();

    exe_stage dut (
        .clk(clk), .reset(reset), .pipe(pipe),
        .es_to_ds_forward_bus(fwd_bus), .es_to_ds_valid(es_to_ds_valid),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .mul_src1(mul_src1), .mul_src2(mul_src2),
        .div_result(div_result), .mod_result(mod_result),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .div_state_dbg(div_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    function automatic logic [215:0] mk_bus(input logic [11:0] aop, input logic [31:0] s1, s2, rkd, csr,
                                            input logic ld, st, input logic [1:0] msz, input logic [3:0] mdop,
                                            input logic dsg, gw, input logic [4:0] dest);
        return {4'b0, 1'b0, 7'b0, 1'b0, 14'h0, csr, 1'b0, 1'b0, msz, mdop, ld, st, dsg, gw, dest,
                aop, s1, s2, rkd, 32'h1c00_0000};
    endfunction

    function automatic logic [W-1:0] mk_exp(input logic [7:0] lat, input logic isdiv, excp, e6,
                                            input logic [31:0] csr, res, q, r);
        return {lat, isdiv, excp, e6, csr, res, q, r};
    endfunction

    function automatic logic [63:0] div_model(input logic [31:0] a, b, input logic sg);
        if (b == 0)  return {32'hFFFF_FFFF, a};
        if (sg)      return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
        return {a / b, a % b};
    endfunction

    function automatic logic [11:0] op_code(input int op);
        case (op)
            0: return 12'h001; 1: return 12'h002; 2: return 12'h010;
            3: return 12'h040; 4: return 12'h080; default: return 12'h100;
        endcase
    endfunction

    function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, b);
        case (op)
            0: return a + b; 1: return a - b; 2: return a & b;
            3: return a | b; 4: return a ^ b; default: return a << b[4:0];
        endcase
    endfunction

    task automatic send(input logic [215:0] bus, input logic [W-1:0] e, input logic do_exp);
        int n = 0;
        pipe.ds_to_es_valid = 1'b1;
        pipe.ds_to_es_bus   = bus;
        while (pipe.es_allowin !== 1'b1 && n < 100) begin tick(); n++; end
        if (n >= 100) check("allowin_wait", pipe.es_allowin, 1);
        if (do_exp) begin exp_q.push_back(e); t_q.push_back(cyc); end
        tick();
        pipe.ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
        if (n >= 200) check("drain", exp_q.size(), 0);
    endtask

    task automatic mem_case(input logic st, ld, input logic [1:0] msz, input logic [31:0] off, rkd,
                            input int exp_en, input logic [3:0] exp_we, input logic [31:0] exp_wd, input logic ale);
        logic [31:0] csr = $urandom;
        en_cnt = 0;
        send(mk_bus(12'h001, 32'h1000, off, rkd, csr, ld, st, msz, 4'b0, 1'b0, ld, ld ? 5'd3 : 5'd0),
             mk_exp(8'd1, 1'b0, ale, ale, csr, 32'h1000 + off, 32'h0, 32'h0), 1'b1);
        tick(3);
        check("sram_en_cnt", en_cnt, exp_en);
        if (exp_en != 0) begin
            check("sram_we", last_we, exp_we);
            check("sram_wdata", last_wdata, exp_wd);
            check("sram_addr", last_addr, 32'h1000 + off);
        end
    endtask

    task automatic div_send(input logic [31:0] a, b, input logic sg);
        logic [31:0] csr = $urandom;
        logic [63:0] m = div_model(a, b, sg);
        send(mk_bus(12'h001, a, b, 32'h0, csr, 1'b0, 1'b0, 2'b10, 4'b0100, sg, 1'b1, 5'd9),
             mk_exp(8'd34, 1'b1, 1'b0, 1'b0, csr, a + b, m[63:32], m[31:0]), 1'b1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (data_sram_en === 1'b1) begin
            en_cnt++;
            last_we = data_sram_we; last_wdata = data_sram_wdata; last_addr = data_sram_addr;
        end
        if (reset === 1'b0 && pipe.es_to_ms_valid === 1'b1 && pipe.ms_allowin === 1'b1) begin
            if (exp_q.size() == 0) check("extra_xfer", exp_q.size(), 1);
            else begin
                mon_e = exp_q.pop_front();
                mon_t = t_q.pop_front();
                check("latency", cyc - mon_t, mon_e[138:131]);
                check("excp", pipe.es_to_ms_bus[77], mon_e[129]);
                check("ale_code", pipe.es_to_ms_bus[132], mon_e[128]);
                check("csr_pass", pipe.es_to_ms_bus[110:79], mon_e[127:96]);
                check("result", pipe.es_to_ms_bus[63:32], mon_e[95:64]);
                if (mon_e[130]) begin
                    check("div_q", div_result, mon_e[63:32]);
                    check("div_r", mod_result, mon_e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1, c2, a, b;
        int op, n;
        reset = 1'b1;
        excp_flush = 1'b0; ertn_flush = 1'b0;
        pipe.ds_to_es_valid = 1'b0; pipe.ds_to_es_bus = '0; pipe.ms_allowin = 1'b1;
        tick(3);
        check("rst_to_ms_valid", pipe.es_to_ms_valid, 0);
        check("rst_allowin", pipe.es_allowin, 1);
        check("rst_sram_en", data_sram_en, 0);
        check("rst_sram_we", data_sram_we, 0);
        check("rst_state", div_state, 0);
        check("rst_div_q", div_result, 0);
        check("rst_div_r", mod_result, 0);
        check("rst_bus", pipe.es_to_ms_bus != '0, 0);
        reset = 1'b0;
        tick();

        // back-to-back ADD 5+7
        c1 = $urandom; c2 = $urandom;
        send(mk_bus(12'h001, 32'd5, 32'd7, 32'h0, c1, 1'b0, 1'b0, 2'b10, 4'b0, 1'b0, 1'b1, 5'd5),
             mk_exp(8'd1, 1'b0, 1'b0, 1'b0, c1, 32'd12, 32'h0, 32'h0), 1'b1);
        check("fwd_bus", fwd_bus, {1'b0, 1'b1, 5'd5, 32'd12});
        check("mul_src1", mul_src1, 32'd5);
        check("mul_src2", mul_src2, 32'd7);
        send(mk_bus(12'h001, 32'd5, 32'd7, 32'h0, c2, 1'b0, 1'b0, 2'b10, 4'b0, 1'b0, 1'b1, 5'd5),
             mk_exp(8'd1, 1'b0, 1'b0, 1'b0, c2, 32'd12, 32'h0, 32'h0), 1'b1);
        tick(2);
        check("fwd_idle", fwd_bus[37], 0);

        for (int i = 0; i < 8; i++) begin
            op = $urandom_range(0, 5); a = $urandom; b = $urandom; c1 = $urandom;
            send(mk_bus(op_code(op), a, b, 32'h0, c1, 1'b0, 1'b0, 2'b10, 4'b0, 1'b0, 1'b1, 5'($urandom_range(1, 31))),
                 mk_exp(8'd1, 1'b0, 1'b0, 1'b0, c1, alu_model(op, a, b), 32'h0, 32'h0), 1'b1);
        end
        wait_drain();

        mem_case(1'b1, 1'b0, 2'b00, 32'd3, 32'h0000_00AB, 1, 4'b1000, 32'hABAB_ABAB, 1'b0);
        mem_case(1'b1, 1'b0, 2'b01, 32'd2, 32'h1234_ABCD, 1, 4'b1100, 32'hABCD_ABCD, 1'b0);
        mem_case(1'b1, 1'b0, 2'b10, 32'd4, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        mem_case(1'b0, 1'b1, 2'b10, 32'd2, 32'h0,         0, 4'b0000, 32'h0,         1'b1);
        mem_case(1'b1, 1'b0, 2'b01, 32'd1, 32'h5555_6666, 0, 4'b0000, 32'h0,         1'b1);
        mem_case(1'b0, 1'b1, 2'b01, 32'd2, 32'h0,         1, 4'b0000, 32'h0000_0000, 1'b0);
        wait_drain();

        // back-to-back divides
        div_send(32'hFFFF_FFF9, 32'd2, 1'b1);
        div_send(32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_drain();

        // divide by zero, mem stalled for 5 cycles in DONE
        c1 = $urandom;
        send(mk_bus(12'h001, 32'h1234, 32'h0, 32'h0, c1, 1'b0, 1'b0, 2'b10, 4'b0100, 1'b0, 1'b1, 5'd9),
             mk_exp(8'd39, 1'b1, 1'b0, 1'b0, c1, 32'h1234, 32'hFFFF_FFFF, 32'h1234), 1'b1);
        pipe.ms_allowin = 1'b0;
        n = 0;
        while (div_state != 2'd2 && n < 100) begin tick(); n++; end
        check("div_done_cycle", n, 33);
        repeat (5) begin
            check("hold_valid", pipe.es_to_ms_valid, 1);
            check("hold_q", div_result, 32'hFFFF_FFFF);
            check("hold_r", mod_result, 32'h1234);
            tick();
        end
        pipe.ms_allowin = 1'b1;
        tick();
        check("after_hold_state", div_state, 0);
        wait_drain();

        // flush in the middle of a divide
        send(mk_bus(12'h001, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 4'b0100, 1'b0, 1'b1, 5'd9), '0, 1'b0);
        tick(10);
        check("pre_flush_state", div_state, 1);
        excp_flush = 1'b1;
        tick();
        excp_flush = 1'b0;
        check("flush_valid", es_to_ds_valid, 0);
        check("flush_state", div_state, 0);
        check("flush_q_kept", div_result, 32'hFFFF_FFFF);
        check("flush_r_kept", mod_result, 32'h1234);
        tick(40);
        check("flush_q_late", div_result, 32'hFFFF_FFFF);

        // flush coinciding with an incoming load and an incoming divide
        en_cnt = 0;
        excp_flush = 1'b1;
        send(mk_bus(12'h001, 32'h1000, 32'd4, 32'h0, 32'h0, 1'b1, 1'b0, 2'b10, 4'b0, 1'b0, 1'b1, 5'd3), '0, 1'b0);
        excp_flush = 1'b0;
        check("flush_in_valid", es_to_ds_valid, 0);
        tick(2);
        check("flush_in_en", en_cnt, 0);
        ertn_flush = 1'b1;
        send(mk_bus(12'h001, 32'd50, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 4'b0100, 1'b0, 1'b1, 5'd9), '0, 1'b0);
        ertn_flush = 1'b0;
        tick(3);
        check("flush_in_div_state", div_state, 0);
        check("flush_in_div_valid", es_to_ds_valid, 0);

        // asynchronous reset while BUSY
        send(mk_bus(12'h001, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 4'b0100, 1'b1, 1'b1, 5'd9), '0, 1'b0);
        tick(5);
        #3 reset = 1'b1;
        #1;
        check("arst_state", div_state, 0);
        check("arst_valid", es_to_ds_valid, 0);
        check("arst_to_ms", pipe.es_to_ms_valid, 0);
        check("arst_en", data_sram_en, 0);
        check("arst_we", data_sram_we, 0);
        check("arst_div_q", div_result, 0);
        check("arst_div_r", mod_result, 0);
        check("arst_bus", pipe.es_to_ms_bus != '0, 0);
        tick(2);
        reset = 1'b0;
        tick();

        c1 = $urandom;
        send(mk_bus(12'h002, 32'd20, 32'd8, 32'h0, c1, 1'b0, 1'b0, 2'b10, 4'b0, 1'b0, 1'b1, 5'd4),
             mk_exp(8'd1, 1'b0, 1'b0, 1'b0, c1, 32'd12, 32'h0, 32'h0), 1'b1);
        wait_drain();
        tick(2);
        check("pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
